bist_signature_checker: RTL and testbench

//   Response-side partner of the BIST controller. Compacts circuit-under-test

---
 rtl/bist_signature_checker.sv | 117 +++++++++++
 tb/tb_bist_signature_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_signature_checker.sv
// Response-side BIST checker: folds CUT responses into a MISR during a run,
// then on FINISH compares signature and vector count against golden values and holds the verdict.
module bist_signature_checker #(
  parameter int              W         = 16,
  parameter logic [W-1:0]    POLY      = 16'h100B,
  parameter logic [W-1:0]    MISR_INIT = '0,
  parameter logic [W-1:0]    GOLDEN    = '0,
  parameter int              CNT_W     = 12,
  parameter int unsigned     EXP_CNT   = 900
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             RUNNING,
  input  logic             OUT,
  input  logic             FINISH,
  input  logic [W-1:0]     CUT_RESP,
  output logic [W-1:0]     SIGNATURE,
  output logic [CNT_W-1:0] VEC_CNT,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL,
  output logic [1:0]       STATE
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPACT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  // Strobe semantics: a vector is offered when RUNNING & OUT; there is no
  // back-pressure, and FINISH in the same cycle discards the offered vector.
  logic             en;
  logic             run_prev;
  logic             run_rise;
  logic [W-1:0]     misr_step;
  logic [W-1:0]     misr_init_step;
  logic [CNT_W-1:0] cnt_inc;
  logic             sig_ok;
  logic             cnt_ok;

  assign en       = RUNNING & OUT & ~FINISH;
  assign run_rise = RUNNING & ~run_prev;

  assign misr_step      = {SIGNATURE[W-2:0], 1'b0} ^ (SIGNATURE[W-1] ? POLY : '0) ^ CUT_RESP;
  assign misr_init_step = {MISR_INIT[W-2:0], 1'b0} ^ (MISR_INIT[W-1] ? POLY : '0) ^ CUT_RESP;

  assign cnt_inc = (VEC_CNT == {CNT_W{1'b1}}) ? VEC_CNT : VEC_CNT + CNT_W'(1);

  assign sig_ok = (SIGNATURE == GOLDEN);
  assign cnt_ok = ({{(32-CNT_W){1'b0}}, VEC_CNT} == EXP_CNT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      run_prev <= 1'b0;
    end else begin
      run_prev <= RUNNING;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      STATE     <= IDLE;
      SIGNATURE <= MISR_INIT;
      VEC_CNT   <= '0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      case (STATE)
        IDLE: begin
          if (FINISH) begin
            // FINISH without any run is always a failure.
            DONE  <= 1'b1;
            PASS  <= 1'b0;
            FAIL  <= 1'b1;
            STATE <= HOLD;
          end else if (en) begin
            SIGNATURE <= misr_step;
            VEC_CNT   <= CNT_W'(1);
            STATE     <= COMPACT;
          end else if (RUNNING) begin
            STATE <= COMPACT;
          end
        end
        COMPACT: begin
          if (FINISH) begin
            DONE  <= 1'b1;
            PASS  <= sig_ok & cnt_ok;
            FAIL  <= ~(sig_ok & cnt_ok);
            STATE <= HOLD;
          end else if (en) begin
            SIGNATURE <= misr_step;
            VEC_CNT   <= cnt_inc;
          end
        end
        HOLD: begin
          if (run_rise) begin
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
            SIGNATURE <= en ? misr_init_step : MISR_INIT;
            VEC_CNT   <= en ? CNT_W'(1) : '0;
            STATE     <= COMPACT;
          end
        end
        default: begin
          STATE     <= IDLE;
          SIGNATURE <= MISR_INIT;
          VEC_CNT   <= '0;
          DONE      <= 1'b0;
          PASS      <= 1'b0;
          FAIL      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: two instances differing only in expected count,
// directed steps followed by random runs, all checked against a list-based reference model.
module tb_bist_signature_checker;

  logic       CLK;
  logic       RESET_N;
  logic       RUNNING;
  logic       OUT;
  logic       FINISH;
  logic [3:0] CUT_RESP;

  logic [3:0] sig_a, sig_b;
  logic [3:0] cnt_a, cnt_b;
  logic       done_a, done_b, pass_a, pass_b, fail_a, fail_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  bist_signature_checker #(
    .W(4), .POLY(4'h3), .MISR_INIT(4'h0), .GOLDEN(4'h3), .CNT_W(4), .EXP_CNT(3)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .OUT(OUT), .FINISH(FINISH),
    .CUT_RESP(CUT_RESP), .SIGNATURE(sig_a), .VEC_CNT(cnt_a), .DONE(done_a),
    .PASS(pass_a), .FAIL(fail_a), .STATE(st_a)
  );

  bist_signature_checker #(
    .W(4), .POLY(4'h3), .MISR_INIT(4'h0), .GOLDEN(4'h3), .CNT_W(4), .EXP_CNT(4)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .OUT(OUT), .FINISH(FINISH),
    .CUT_RESP(CUT_RESP), .SIGNATURE(sig_b), .VEC_CNT(cnt_b), .DONE(done_b),
    .PASS(pass_b), .FAIL(fail_b), .STATE(st_b)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the run is kept as the list of vectors actually compacted.
  int         m_mode;       // 0 = no run yet, 1 = running, 2 = verdict held
  logic [3:0] m_vecs[$];
  bit         m_prev_r;
  bit         m_done;
  bit         m_pass_a;
  bit         m_pass_b;

  function automatic logic [3:0] m_sig();
    int s = 0;
    foreach (m_vecs[i]) s = ((s * 2) % 16) ^ ((s >= 8) ? 3 : 0) ^ int'(m_vecs[i]);
    return 4'(s);
  endfunction

  function automatic int m_cnt();
    return (m_vecs.size() > 15) ? 15 : m_vecs.size();
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_vecs.delete();
    m_prev_r = 0;
    m_done = 0;
    m_pass_a = 0;
    m_pass_b = 0;
  endtask

  task automatic model_step(input bit r, input bit o, input bit f, input logic [3:0] d);
    bit accept;
    accept = r && o && !f;
    if (m_mode == 0) begin
      if (f) begin
        m_done = 1; m_pass_a = 0; m_pass_b = 0; m_mode = 2;
      end else if (r) begin
        if (accept) m_vecs.push_back(d);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (f) begin
        m_done = 1;
        m_pass_a = (m_sig() == 4'h3) && (m_cnt() == 3);
        m_pass_b = (m_sig() == 4'h3) && (m_cnt() == 4);
        m_mode = 2;
      end else if (accept) begin
        m_vecs.push_back(d);
      end
    end else begin
      if (r && !m_prev_r) begin
        m_done = 0; m_pass_a = 0; m_pass_b = 0;
        m_vecs.delete();
        if (accept) m_vecs.push_back(d);
        m_mode = 1;
      end
    end
    m_prev_r = r;
  endtask

  // Scoreboard primitives
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " sig_a"},  32'(sig_a),  32'(m_sig()));
    chk({tag, " cnt_a"},  32'(cnt_a),  32'(m_cnt()));
    chk({tag, " done_a"}, 32'(done_a), 32'(m_done));
    chk({tag, " pass_a"}, 32'(pass_a), 32'(m_done && m_pass_a));
    chk({tag, " fail_a"}, 32'(fail_a), 32'(m_done && !m_pass_a));
    chk({tag, " sig_b"},  32'(sig_b),  32'(m_sig()));
    chk({tag, " cnt_b"},  32'(cnt_b),  32'(m_cnt()));
    chk({tag, " done_b"}, 32'(done_b), 32'(m_done));
    chk({tag, " pass_b"}, 32'(pass_b), 32'(m_done && m_pass_b));
    chk({tag, " fail_b"}, 32'(fail_b), 32'(m_done && !m_pass_b));
  endtask

  // Driver: inputs change 1 time unit after a rising edge, outputs checked 1 unit after the next.
  task automatic cyc(input string tag, input bit r, input bit o, input bit f, input logic [3:0] d);
    RUNNING = r; OUT = o; FINISH = f; CUT_RESP = d;
    @(posedge CLK);
    #1;
    model_step(r, o, f, d);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    RUNNING = 1'b0; OUT = 1'b0; FINISH = 1'b0; CUT_RESP = 4'h0;
    #1;
    model_reset();
    check_all({tag, " async"});
    @(posedge CLK);
    #1;
    check_all({tag, " held"});
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; RUNNING = 1'b0; OUT = 1'b0; FINISH = 1'b0; CUT_RESP = 4'h0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset("reset");

    // T1: 1,2,3 -> signatures 1,0,3; EXP_CNT=3 passes, EXP_CNT=4 fails
    cyc("t1 v1", 1, 1, 0, 4'h1); chk("t1 sig1", 32'(sig_a), 32'h1);
    cyc("t1 v2", 1, 1, 0, 4'h2); chk("t1 sig2", 32'(sig_a), 32'h0);
    cyc("t1 v3", 1, 1, 0, 4'h3); chk("t1 sig3", 32'(sig_a), 32'h3);
    chk("t1 done before finish", 32'(done_a), 32'h0);
    cyc("t1 fin", 0, 0, 1, 4'h0);
    chk("t1 done", 32'(done_a), 32'h1);
    chk("t1 pass", 32'(pass_a), 32'h1);
    chk("t1 fail", 32'(fail_a), 32'h0);
    chk("t1 fail exp4", 32'(fail_b), 32'h1);

    // T2: restart from HOLD on RUNNING rise; 1,2,2 -> signature 2, fail
    cyc("t2 v1", 1, 1, 0, 4'h1);
    chk("t2 done cleared", 32'(done_a), 32'h0);
    chk("t2 cnt restart", 32'(cnt_a), 32'h1);
    cyc("t2 v2", 1, 1, 0, 4'h2);
    cyc("t2 v3", 1, 1, 0, 4'h2); chk("t2 sig", 32'(sig_a), 32'h2);
    cyc("t2 fin", 0, 0, 1, 4'h0);
    chk("t2 fail", 32'(fail_a), 32'h1);
    chk("t2 pass", 32'(pass_a), 32'h0);

    // T3: feedback tap and OUT=0 gaps
    cyc("t3 v1", 1, 1, 0, 4'h8); chk("t3 sig8", 32'(sig_a), 32'h8);
    cyc("t3 gap", 1, 0, 0, 4'h5); chk("t3 gap cnt", 32'(cnt_a), 32'h1);
    cyc("t3 v2", 1, 1, 0, 4'h0); chk("t3 sig3", 32'(sig_a), 32'h3);
    cyc("t3 idle run", 0, 1, 0, 4'h6);
    cyc("t3 fin", 0, 0, 1, 4'h0);

    // T4: 4th vector dropped by OUT=0, 5th dropped by FINISH priority
    cyc("t4 v1", 1, 1, 0, 4'h1);
    cyc("t4 v2", 1, 1, 0, 4'h2);
    cyc("t4 v3", 1, 1, 0, 4'h3);
    cyc("t4 drop", 1, 0, 0, 4'h4);
    cyc("t4 fin+en", 1, 1, 1, 4'h4);
    chk("t4 sig", 32'(sig_b), 32'h3);
    chk("t4 cnt", 32'(cnt_b), 32'h3);
    chk("t4 fail exp4", 32'(fail_b), 32'h1);
    cyc("t4 hold en", 1, 1, 0, 4'h9);
    cyc("t4 refinish", 0, 1, 1, 4'h5);
    chk("t4 frozen sig", 32'(sig_b), 32'h3);

    // T5: reset in the middle of a run, then a clean run from IDLE
    cyc("t5 v1", 1, 1, 0, 4'h7);
    cyc("t5 v2", 1, 1, 0, 4'h9);
    do_reset("t5 reset");
    chk("t5 sig reset", 32'(sig_a), 32'h0);
    cyc("t5 idle", 0, 0, 0, 4'h0);
    cyc("t5 v", 1, 1, 0, 4'hA);
    cyc("t5 fin", 0, 0, 1, 4'h0);

    // T6: FINISH with no run, then counter saturation
    do_reset("t6 reset");
    cyc("t6 fin idle", 0, 0, 1, 4'h0);
    chk("t6 done", 32'(done_a), 32'h1);
    chk("t6 fail", 32'(fail_a), 32'h1);
    cyc("t6 low", 0, 0, 0, 4'h0);
    for (int i = 0; i < 17; i++) cyc("t6 sat", 1, 1, 0, 4'($urandom_range(0, 15)));
    chk("t6 cnt sat", 32'(cnt_a), 32'hF);
    cyc("t6 fin", 0, 0, 1, 4'h0);

    // Random runs
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd reset");
      end else begin
        cyc("rnd",
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0,
            4'($urandom_range(0, 15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
